mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Sequencing arbiter between the single-ported unified RAM and the datapath's two memory requesters: instruction fetch and data load/store. The control unit's read/write enables drive it. It serialises fetch and data accesses with data priority and one-data-access-per-instruction locking. It also enforces halt and bounds RAM wait states with a timeout. It sits between the datapath/control unit and the RAM model, replacing direct RAM wiring.

## Interface
- MAX_WAIT, 16: cycles an access may stay un-ACCESSed before timeout (≥2)
- CLK  in  1  system clock, rising edge
- RST  in  1  asynchronous, active-high reset
- iREN  in  1  instruction fetch request
- iaddr  in  32  fetch word address (word_t)
- dREN  in  1  data read request (control unit dMemRe)
- dWEN  in  1  data write request (control unit dMemWr)
- daddr  in  32  data address (word_t)
- dstore  in  32  store data
- halt  in  1  halt request from control unit
- ihit  out  1  fetch complete, one-cycle pulse
- iload  out  32  fetched word, valid when ihit
- dhit  out  1  data access complete, one-cycle pulse
- dload  out  32  loaded word, valid when dhit
- halted  out  1  sticky halted flag
- timeout  out  1  one-cycle pulse, access abandoned
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR

## Operation
- States: IDLE, IREQ, DREQ, HALTED (arb_state_t).
- IDLE, priority order:
  - dREN|dWEN and dlock=0 → DREQ. Latch daddr, dstore, wr=dWEN; dWEN wins if both are set.
  - Else halt=1 → HALTED.
  - Else iREN → IREQ. Latch iaddr.
  - Else stay.
- IREQ: ramREN=1, ramaddr=iaddr_q.
  - ramstate==ACCESS: ihit=1, iload=ramload, dlock←0, wait counter cleared → IDLE.
- DREQ: ramaddr=daddr_q.
  - wr=1: ramWEN=1, ramstore=dstore_q.
  - wr=0: ramREN=1.
  - ramstate==ACCESS: dhit=1, dload=ramload (0 on write), dlock←1, counter cleared → IDLE.
- ERROR in IREQ/DREQ: hold request (retry). Counter keeps running.
- Wait counter: 0 on entry to IREQ/DREQ, +1 each non-ACCESS cycle. At MAX_WAIT-1 without ACCESS: timeout=1, no hit, counter cleared → IDLE. dlock is unchanged on timeout.
- dlock: blocks data requests after a dhit until the next ihit. This guarantees one data access per instruction.
- HALTED: absorbing until RST. All RAM enables, hits and timeout are 0; halted=1.
- halt never aborts an IREQ/DREQ in flight. It is acted on only in IDLE, after pending unlocked data.
- All outputs not listed as active in a state are 0 in that state. iload/dload are 0 when their hit is 0.

## Timing
- Reset (async, immediate): state=IDLE, dlock=0, counter=0, latched regs=0. All outputs 0.
- Requests sampled in IDLE at the rising edge. RAM driven from the next cycle.
- ihit/dhit/timeout are combinational in the cycle ACCESS/limit is seen. Minimum latency 1 cycle after the request cycle; zero-wait RAM gives a hit on cycle N+1 for a request at N.
- Back-to-back: after a hit the arbiter spends one cycle in IDLE before re-granting. Steady-state fetch throughput is 1 word per 2 cycles with zero-wait RAM.
- Requester changes to iaddr/daddr after grant are ignored (latched copy used).
- Simultaneous: dREN+iREN in IDLE with dlock=0 → data first. halt+iREN → HALTED. halt+unlocked data → data first, then HALTED.
- RST asserted mid-IREQ/DREQ: RAM enables drop in the same cycle, and the access is discarded.

## Structure
- arb_state_t (IDLE, IREQ, DREQ, HALTED) added to cpu_types_pkg alongside the existing ramstate_t and word_t.
- One sub-module: mem_wait_timer. Parameterised MAX_WAIT down-counter with clear/enable/expired, width $clog2(MAX_WAIT).
- FSM, latches and output muxing live in mem_arbiter.

## Test plan
- Zero-wait RAM, iREN=1 at iaddr=0x0000_0040, RAM word 0x2108_0001 → ihit on cycle 2, iload=0x2108_0001; ramREN=1 only during IREQ.
- iREN and dREN both high, daddr=0x0000_0100 (holds 0xDEAD_BEEF) → dhit/dload=0xDEAD_BEEF first. dREN held high afterwards is ignored (dlock) until the following ihit.
- dWEN=1, daddr=0x80, dstore=0x1234_5678, RAM BUSY 3 cycles → ramWEN=1, ramstore=0x1234_5678 for 4 cycles, then dhit, dload=0. Readback returns 0x1234_5678.
- MAX_WAIT=4, RAM stuck BUSY on a fetch → timeout pulse on the 4th IREQ cycle, no ihit, back to IDLE. The next fetch is re-issued.
- halt=1 during a 2-wait-state fetch → fetch completes with ihit, then HALTED. halted=1, ramREN/ramWEN stay 0 despite iREN=1.
- RST pulsed on the 2nd cycle of DREQ → all outputs 0 immediately, state IDLE, dlock=0. The next dREN is granted normally.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, RAM handshake states and arbiter FSM states.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IREQ   = 2'd1,
    DREQ   = 2'd2,
    HALTED = 2'd3
  } arb_state_t;

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-state budget for one RAM access. Loaded with MAX_WAIT-1 when cleared,
// counts down once per stalled cycle; expired means the budget is used up.
module mem_wait_timer #(
  parameter int MAX_WAIT = 16
) (
  input  logic CLK,
  input  logic RST,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(MAX_WAIT);
  localparam logic [CW-1:0] LOAD = CW'(MAX_WAIT - 1);

  logic [CW-1:0] cnt;

  // Reload on clear, otherwise burn one unit per stalled cycle, saturating at 0
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt <= LOAD;
    end else if (clear) begin
      cnt <= LOAD;
    end else if (enable && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter between instruction fetch and data load/store on the shared RAM.
// Data wins over fetch, but only once per instruction (dlock); halt is taken
// only from IDLE; a stalled access is abandoned after MAX_WAIT cycles.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int MAX_WAIT = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  input  logic        halt,
  output logic        ihit,
  output logic [31:0] iload,
  output logic        dhit,
  output logic [31:0] dload,
  output logic        halted,
  output logic        timeout,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate
);

  arb_state_t state, next_state;
  ramstate_t  rs;
  word_t      iaddr_q, daddr_q, dstore_q;
  logic       wr_q, dlock;
  logic       busy, acc, d_grant, i_grant;
  logic       tmr_clear, tmr_en, tmr_expired;

  assign rs      = ramstate_t'(ramstate);
  assign acc     = (rs == ACCESS);
  assign busy    = (state == IREQ) || (state == DREQ);
  assign d_grant = (state == IDLE) && (dREN || dWEN) && !dlock;
  assign i_grant = (state == IDLE) && !d_grant && !halt && iREN;

  // Fresh budget while idle and after every completed or abandoned access
  assign tmr_clear = !busy || acc || tmr_expired;
  assign tmr_en    = busy && !acc;

  mem_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
    .CLK     (CLK),
    .RST     (RST),
    .clear   (tmr_clear),
    .enable  (tmr_en),
    .expired (tmr_expired)
  );

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state: data before halt before fetch; HALTED is absorbing
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (d_grant)     next_state = DREQ;
        else if (halt)   next_state = HALTED;
        else if (i_grant) next_state = IREQ;
      end
      IREQ, DREQ: begin
        if (acc || tmr_expired) next_state = IDLE;
      end
      default: next_state = HALTED;
    endcase
  end

  // Request latches and the one-data-access-per-instruction lock
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      iaddr_q  <= '0;
      daddr_q  <= '0;
      dstore_q <= '0;
      wr_q     <= 1'b0;
      dlock    <= 1'b0;
    end else begin
      if (d_grant) begin
        daddr_q  <= daddr;
        dstore_q <= dstore;
        wr_q     <= dWEN;
      end
      if (i_grant) iaddr_q <= iaddr;
      if ((state == IREQ) && acc) dlock <= 1'b0;
      if ((state == DREQ) && acc) dlock <= 1'b1;
    end
  end

  // Outputs: RAM drive and hit/timeout pulses decoded from state and RAM status
  always_comb begin
    ihit     = 1'b0;
    iload    = '0;
    dhit     = 1'b0;
    dload    = '0;
    halted   = 1'b0;
    timeout  = 1'b0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    case (state)
      IREQ: begin
        ramREN  = 1'b1;
        ramaddr = iaddr_q;
        if (acc) begin
          ihit  = 1'b1;
          iload = ramload;
        end else if (tmr_expired) begin
          timeout = 1'b1;
        end
      end
      DREQ: begin
        ramaddr = daddr_q;
        if (wr_q) begin
          ramWEN   = 1'b1;
          ramstore = dstore_q;
        end else begin
          ramREN = 1'b1;
        end
        if (acc) begin
          dhit  = 1'b1;
          dload = wr_q ? '0 : ramload;
        end else if (tmr_expired) begin
          timeout = 1'b1;
        end
      end
      HALTED: halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboarded bench for mem_arbiter with a behavioural wait-state RAM.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int MAXW = 4;
  localparam logic [1:0] K_I = 2'd0, K_D = 2'd1, K_T = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] data;
  } exp_t;

  logic        CLK, RST, iREN, dREN, dWEN, halt;
  logic [31:0] iaddr, daddr, dstore, iload, dload, ramaddr, ramstore, ramload;
  logic        ihit, dhit, halted, timeout, ramREN, ramWEN;
  logic [1:0]  ramstate;

  logic [31:0] mem [0:255];
  int          busy_cnt, ram_wait;
  logic        ram_stuck;
  logic [1:0]  wait_kind;
  logic        pl_we;
  logic [7:0]  pl_idx;
  logic [31:0] pl_data;

  int   vectors, miscompares, evt_seen, target;
  exp_t sb[$];
  exp_t mon_act, mon_e;

  mem_arbiter #(.MAX_WAIT(MAXW)) dut (
    .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
    .daddr(daddr), .dstore(dstore), .halt(halt), .ihit(ihit), .iload(iload),
    .dhit(dhit), .dload(dload), .halted(halted), .timeout(timeout),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // RAM model: ram_wait stall cycles (BUSY or ERROR) then ACCESS
  always_comb begin
    ramstate = FREE;
    if (ramREN || ramWEN) begin
      if (ram_stuck || (busy_cnt < ram_wait)) ramstate = wait_kind;
      else                                    ramstate = ACCESS;
    end
  end
  assign ramload = mem[ramaddr[9:2]];

  always @(posedge CLK) begin
    if (pl_we) mem[pl_idx] <= pl_data;
    else if (ramWEN && (ramstate == ACCESS)) mem[ramaddr[9:2]] <= ramstore;
    if ((ramREN || ramWEN) && (ramstate != ACCESS)) busy_cnt <= busy_cnt + 1;
    else busy_cnt <= 0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every hit/timeout pulse is matched against the scoreboard head
  always @(negedge CLK) begin
    if (!RST && (ihit || dhit || timeout)) begin
      evt_seen++;
      if (ihit)      mon_act = exp_t'{K_I, iload};
      else if (dhit) mon_act = exp_t'{K_D, dload};
      else           mon_act = exp_t'{K_T, iload | dload};
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_evt: got kind %0d data %h, expected none", mon_act.kind, mon_act.data);
      end else begin
        mon_e = sb.pop_front();
        chk("evt_kind", 32'(mon_act.kind), 32'(mon_e.kind));
        chk("evt_data", mon_act.data, mon_e.data);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic half();
    @(negedge CLK);
  endtask

  task automatic wait_evts(input string name, input int tgt);
    for (int i = 0; i < 40 && evt_seen < tgt; i++) tick();
    chk(name, 32'(evt_seen), 32'(tgt));
  endtask

  // One complete transaction issued from IDLE, returns with the arbiter back in IDLE
  task automatic xact(input string name, input logic [1:0] kind, input logic wr,
                      input logic [31:0] addr, input logic [31:0] store, input logic [31:0] expv);
    int tgt;
    tgt = evt_seen + 1;
    sb.push_back(exp_t'{kind, expv});
    if (kind == K_I) begin
      iREN = 1'b1; iaddr = addr;
    end else begin
      dREN = !wr; dWEN = wr; daddr = addr; dstore = store;
    end
    tick();
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    wait_evts(name, tgt);
  endtask

  task automatic preload(input logic [31:0] addr, input logic [31:0] data);
    pl_we = 1'b1; pl_idx = addr[9:2]; pl_data = data;
    tick();
    pl_we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "stuck");
  end

  initial begin
    vectors = 0; miscompares = 0; evt_seen = 0;
    RST = 1'b1; iREN = 0; dREN = 0; dWEN = 0; halt = 0;
    iaddr = '0; daddr = '0; dstore = '0;
    ram_wait = 0; ram_stuck = 0; wait_kind = BUSY; pl_we = 0; pl_idx = '0; pl_data = '0;
    preload(32'h0000_0040, 32'h2108_0001);
    preload(32'h0000_0100, 32'hDEAD_BEEF);
    preload(32'h0000_0080, 32'h0000_0000);
    half();
    chk("rst_flags", 32'({ihit, dhit, timeout, halted, ramREN, ramWEN}), 32'd0);
    chk("rst_ramaddr", ramaddr, 32'd0);
    chk("rst_loads", iload | dload | ramstore, 32'd0);
    tick();
    RST = 1'b0;

    // Zero-wait fetch: hit in the cycle after the request, RAM enabled only in IREQ
    iREN = 1'b1; iaddr = 32'h0000_0040;
    sb.push_back(exp_t'{K_I, 32'h2108_0001});
    half();
    chk("t1_idle_ren", 32'(ramREN), 32'd0);
    tick(); iREN = 1'b0; iaddr = 32'h0000_0FFC;
    half();
    chk("t1_ihit_lat", 32'(ihit), 32'd1);
    chk("t1_ren", 32'(ramREN), 32'd1);
    chk("t1_addr", ramaddr, 32'h0000_0040);
    tick(); half();
    chk("t1_after_ren", 32'(ramREN), 32'd0);

    // Data beats fetch; held dREN is locked out until the next ihit
    tick();
    iREN = 1'b1; iaddr = 32'h0000_0040; dREN = 1'b1; daddr = 32'h0000_0100;
    sb.push_back(exp_t'{K_D, 32'hDEAD_BEEF});
    sb.push_back(exp_t'{K_I, 32'h2108_0001});
    sb.push_back(exp_t'{K_D, 32'hDEAD_BEEF});
    tick(); iREN = 1'b0;
    half();
    chk("t2_daddr", ramaddr, 32'h0000_0100);
    tick(); tick(); iREN = 1'b1;
    half();
    chk("t2_dlock", 32'(ramREN), 32'd0);
    tick(); iREN = 1'b0;
    half();
    chk("t2_fetch_addr", ramaddr, 32'h0000_0040);
    tick(); tick(); dREN = 1'b0;
    tick();
    chk("t2_events", 32'(evt_seen), 32'd4);

    // Write with 3 BUSY cycles: ACCESS lands exactly on the last allowed cycle
    xact("t3_unlock", K_I, 1'b0, 32'h0000_0040, 32'h0, 32'h2108_0001);
    ram_wait = 3;
    dWEN = 1'b1; dREN = 1'b1; daddr = 32'h0000_0080; dstore = 32'h1234_5678;
    sb.push_back(exp_t'{K_D, 32'h0000_0000});
    tick();
    dWEN = 1'b0; dREN = 1'b0; daddr = 32'h0000_0FFC; dstore = '0;
    for (int i = 0; i < 4; i++) begin
      half();
      chk("t3_wen", 32'({ramWEN, ramREN}), 32'b10);
      chk("t3_store", ramstore, 32'h1234_5678);
      chk("t3_dhit", 32'(dhit), 32'(i == 3));
      tick();
    end
    ram_wait = 2; wait_kind = ERROR;
    xact("t3_err_fetch", K_I, 1'b0, 32'h0000_0080, 32'h0, 32'h1234_5678);
    ram_wait = 0; wait_kind = BUSY;
    xact("t3_readback", K_D, 1'b0, 32'h0000_0080, 32'h0, 32'h1234_5678);

    // RAM stuck BUSY: timeout on the 4th IREQ cycle, dlock survives it
    ram_stuck = 1'b1;
    sb.push_back(exp_t'{K_T, 32'h0});
    iREN = 1'b1; iaddr = 32'h0000_0040;
    tick(); iREN = 1'b0;
    for (int i = 0; i < 4; i++) begin
      half();
      chk("t4_ren", 32'(ramREN), 32'd1);
      chk("t4_timeout", 32'(timeout), 32'(i == 3));
      tick();
    end
    half();
    chk("t4_idle", 32'(ramREN), 32'd0);
    ram_stuck = 1'b0;
    tick();
    target = evt_seen + 2;
    iREN = 1'b1; iaddr = 32'h0000_0040; dREN = 1'b1; daddr = 32'h0000_0100;
    sb.push_back(exp_t'{K_I, 32'h2108_0001});
    sb.push_back(exp_t'{K_D, 32'hDEAD_BEEF});
    tick(); iREN = 1'b0;
    half();
    chk("t4_dlock_kept", ramaddr, 32'h0000_0040);
    wait_evts("t4_refetch", target);
    dREN = 1'b0;

    // Halt during a 2-wait fetch: fetch completes, then HALTED ignores requests
    ram_wait = 2;
    iREN = 1'b1; iaddr = 32'h0000_0040;
    sb.push_back(exp_t'{K_I, 32'h2108_0001});
    tick(); halt = 1'b1;
    half();
    chk("t5_inflight", 32'(ramREN), 32'd1);
    tick(); tick();
    half();
    chk("t5_ihit", 32'(ihit), 32'd1);
    tick();
    half();
    chk("t5_idle", 32'({halted, ramREN}), 32'd0);
    tick();
    half();
    chk("t5_halted", 32'({halted, ramREN, ramWEN}), 32'b100);
    tick(); dWEN = 1'b1;
    half();
    chk("t5_absorb", 32'({halted, ramREN, ramWEN}), 32'b100);

    // Reset: leaves HALTED, kills an in-flight DREQ, clears dlock
    tick();
    RST = 1'b1; halt = 1'b0; iREN = 1'b0; dWEN = 1'b0;
    #1;
    chk("t6_rst_halted", 32'({halted, ramREN, ramWEN}), 32'd0);
    tick(); RST = 1'b0;
    ram_wait = 3;
    dREN = 1'b1; daddr = 32'h0000_0100;
    tick(); dREN = 1'b0;
    half();
    chk("t6_dreq", 32'(ramREN), 32'd1);
    tick();
    RST = 1'b1;
    #1;
    chk("t6_rst_flags", 32'({ihit, dhit, timeout, halted, ramREN, ramWEN}), 32'd0);
    chk("t6_rst_addr", ramaddr, 32'd0);
    tick(); RST = 1'b0;
    ram_wait = 0;
    xact("t6_after_rst", K_D, 1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF);
    RST = 1'b1;
    tick(); RST = 1'b0;
    xact("t6_dlock_clr", K_D, 1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF);

    tick(); tick();
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
